// File: rtl/ltl_symbol_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ltl_monitor_pkg
// Description : Shared widths, streamer state type and helpers for the
//               automata symbol streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package ltl_monitor_pkg;

    localparam int SYMBOL_W   = 8;
    localparam int DROP_CNT_W = 16;
    localparam int SYM_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } stream_state_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] value);
        return (value == {DROP_CNT_W{1'b1}}) ? value : value + DROP_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ltl_symbol_streamer_if.sv
`default_nettype none
// ============================================================================
// Interface   : ltl_symbol_streamer_if
// Description : Trace-in / symbol-out bundle between trace tap, streamer and
//               automata clusters.
// Revision    : 1.0 - initial release
// ============================================================================
interface ltl_symbol_streamer_if;
    import ltl_monitor_pkg::*;

    logic                  enable_i;
    logic                  prop_valid_i;
    logic [SYMBOL_W-1:0]   prop_i;
    logic                  stall_i;
    logic [SYMBOL_W-1:0]   symbols_o;
    logic                  run_o;
    logic                  am_reset_o;
    logic                  busy_o;
    logic                  overflow_o;
    logic [DROP_CNT_W-1:0] drop_cnt_o;
    logic [SYM_CNT_W-1:0]  sym_cnt_o;

    modport master (
        output enable_i, prop_valid_i, prop_i, stall_i,
        input  symbols_o, run_o, am_reset_o, busy_o, overflow_o, drop_cnt_o, sym_cnt_o
    );

    modport slave (
        input  enable_i, prop_valid_i, prop_i, stall_i,
        output symbols_o, run_o, am_reset_o, busy_o, overflow_o, drop_cnt_o, sym_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/ltl_symbol_streamer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ltl_sym_fifo
// Description : Synchronous symbol FIFO with flush; a push while full is
//               accepted when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ltl_sym_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ltl_symbol_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ltl_symbol_streamer
// Description : Turns per-cycle trace propositions into the automata symbol
//               stream, run strobe and sequenced automaton reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ltl_symbol_streamer
    import ltl_monitor_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int RESET_CYCLES = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    ltl_symbol_streamer_if.slave bus
);

    localparam int c_ARM_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

    stream_state_e         r_state;
    stream_state_e         w_next_state;
    logic [c_ARM_W-1:0]    r_arm_cnt;
    logic [SYMBOL_W-1:0]   r_symbols;
    logic                  r_run;
    logic                  r_am_reset;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [SYM_CNT_W-1:0]  r_sym_cnt;

    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_arm_entry;
    logic                  w_arm_done;
    logic                  w_drop;
    logic [SYMBOL_W-1:0]   w_head;
    logic                  w_full;
    logic                  w_empty;

    ltl_sym_fifo #(
        .WIDTH (SYMBOL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (bus.prop_i),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_arm_done = (r_arm_cnt >= c_ARM_W'(RESET_CYCLES));
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_comb begin
        w_next_state = r_state;
        w_push_req   = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_arm_entry  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.enable_i) begin
                    w_next_state = ST_ARM;
                    w_flush      = 1'b1;
                    w_arm_entry  = 1'b1;
                end
            end
            ST_ARM: begin
                if (!bus.enable_i) begin
                    w_next_state = ST_IDLE;
                    w_flush      = 1'b1;
                end else begin
                    w_push_req = bus.prop_valid_i;
                    // Popping on the exit edge puts the first symbol on the
                    // same edge that releases the automaton reset.
                    if (w_arm_done && !w_empty && !bus.stall_i) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                w_push_req = bus.prop_valid_i;
                w_pop      = !bus.stall_i && !w_empty;
                if (!bus.enable_i) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_pop = !bus.stall_i && !w_empty;
                if (w_empty) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_arm_cnt <= '0;
        end else if (r_state != ST_ARM) begin
            r_arm_cnt <= '0;
        end else if (!w_arm_done) begin
            r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_symbols  <= '0;
            r_run      <= 1'b0;
            r_am_reset <= 1'b1;
        end else begin
            r_run      <= w_pop;
            r_am_reset <= (w_next_state == ST_IDLE) || (w_next_state == ST_ARM);
            if (w_pop) r_symbols <= w_head;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_sym_cnt  <= '0;
        end else if (w_arm_entry) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_sym_cnt  <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc_drop(r_drop_cnt);
            end
            if (w_pop) r_sym_cnt <= r_sym_cnt + SYM_CNT_W'(1);
        end
    end

    assign bus.symbols_o  = r_symbols;
    assign bus.run_o      = r_run;
    assign bus.am_reset_o = r_am_reset;
    assign bus.busy_o     = (r_state != ST_IDLE);
    assign bus.overflow_o = r_overflow;
    assign bus.drop_cnt_o = r_drop_cnt;
    assign bus.sym_cnt_o  = r_sym_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ltl_symbol_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ltl_symbol_streamer
// Description : Self-checking bench: directed table, corner sequences and a
//               random run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltl_symbol_streamer;

    localparam int DEPTH = 4;
    localparam int RC    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ltl_symbol_streamer_if bus ();

    ltl_symbol_streamer #(.FIFO_DEPTH(DEPTH), .RESET_CYCLES(RC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: session phase plus a queue of pending symbols.
    typedef enum {M_IDLE, M_ARM, M_STREAM, M_DRAIN} mphase_e;
    mphase_e    m_phase;
    logic [7:0] m_q[$];
    int         m_arm_cycles;
    logic [7:0] m_sym;
    logic       m_run;
    logic       m_amr;
    logic       m_ovf;
    int         m_drop;
    longint     m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_q.delete(); m_arm_cycles = 0;
        m_sym = 8'h00; m_run = 1'b0; m_amr = 1'b1; m_ovf = 1'b0; m_drop = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic en, input logic pv, input logic [7:0] p, input logic st);
        logic    push = 1'b0;
        logic    pop  = 1'b0;
        mphase_e nxt  = m_phase;
        case (m_phase)
            M_IDLE: if (en) begin
                nxt = M_ARM; m_q.delete(); m_cnt = 0; m_drop = 0; m_ovf = 1'b0; m_arm_cycles = 0;
            end
            M_ARM: begin
                if (!en) begin
                    nxt = M_IDLE; m_q.delete();
                end else begin
                    push = pv;
                    if (m_arm_cycles >= RC && m_q.size() > 0 && !st) begin
                        pop = 1'b1; nxt = M_STREAM;
                    end
                end
                m_arm_cycles++;
            end
            M_STREAM: begin
                push = pv;
                pop  = !st && m_q.size() > 0;
                if (!en) nxt = M_DRAIN;
            end
            M_DRAIN: begin
                pop = !st && m_q.size() > 0;
                if (m_q.size() == 0) nxt = M_IDLE;
            end
        endcase
        m_run = pop;
        if (pop) begin
            m_sym = m_q.pop_front();
            m_cnt++;
        end
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(p);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
        end
        m_phase = nxt;
        m_amr   = (nxt == M_IDLE) || (nxt == M_ARM);
    endtask

    task automatic check_model();
        chk("symbols_o",  32'(bus.symbols_o),  32'(m_sym));
        chk("run_o",      32'(bus.run_o),      32'(m_run));
        chk("am_reset_o", 32'(bus.am_reset_o), 32'(m_amr));
        chk("busy_o",     32'(bus.busy_o),     32'(m_phase != M_IDLE));
        chk("overflow_o", 32'(bus.overflow_o), 32'(m_ovf));
        chk("drop_cnt_o", 32'(bus.drop_cnt_o), 32'(m_drop));
        chk("sym_cnt_o",  bus.sym_cnt_o,       32'(m_cnt));
    endtask

    task automatic step(input logic en, input logic pv, input logic [7:0] p, input logic st);
        bus.enable_i = en; bus.prop_valid_i = pv; bus.prop_i = p; bus.stall_i = st;
        @(posedge clk);
        model_step(en, pv, p, st);
        #1;
        check_model();
    endtask

    typedef struct {
        logic en, pv; logic [7:0] p; logic st;
        logic x_run; logic [7:0] x_sym; logic x_amr; logic x_busy; logic x_ovf; logic [15:0] x_drop;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic pv, input logic [7:0] p, input logic st,
                                input logic r, input logic [7:0] s, input logic a, input logic b,
                                input logic o, input logic [15:0] d);
        vec_t v;
        v.en = en; v.pv = pv; v.p = p; v.st = st;
        v.x_run = r; v.x_sym = s; v.x_amr = a; v.x_busy = b; v.x_ovf = o; v.x_drop = d;
        return v;
    endfunction

    vec_t       tbl[15];
    logic [7:0] got[$];
    logic [7:0] want[$];
    logic       en_r;
    logic       any_run;

    task automatic collect();
        if (bus.run_o) got.push_back(bus.symbols_o);
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++) chk(name, 32'(got[i]), 32'(want[i]));
    endtask

    initial begin
        // Bring-up of one symbol, then a stalled burst with one drop and its release.
        tbl[0]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 1, 1, 0, 16'd0);
        tbl[1]  = mk(1, 1, 8'h35, 0,  0, 8'h00, 1, 1, 0, 16'd0);
        tbl[2]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 1, 1, 0, 16'd0);
        tbl[3]  = mk(1, 0, 8'h00, 0,  1, 8'h35, 0, 1, 0, 16'd0);
        tbl[4]  = mk(1, 0, 8'h00, 0,  0, 8'h35, 0, 1, 0, 16'd0);
        tbl[5]  = mk(1, 1, 8'h01, 1,  0, 8'h35, 0, 1, 0, 16'd0);
        tbl[6]  = mk(1, 1, 8'h02, 1,  0, 8'h35, 0, 1, 0, 16'd0);
        tbl[7]  = mk(1, 1, 8'h03, 1,  0, 8'h35, 0, 1, 0, 16'd0);
        tbl[8]  = mk(1, 1, 8'h04, 1,  0, 8'h35, 0, 1, 0, 16'd0);
        tbl[9]  = mk(1, 1, 8'h05, 1,  0, 8'h35, 0, 1, 1, 16'd1);
        tbl[10] = mk(1, 0, 8'h00, 0,  1, 8'h01, 0, 1, 1, 16'd1);
        tbl[11] = mk(1, 0, 8'h00, 0,  1, 8'h02, 0, 1, 1, 16'd1);
        tbl[12] = mk(1, 0, 8'h00, 0,  1, 8'h03, 0, 1, 1, 16'd1);
        tbl[13] = mk(1, 0, 8'h00, 0,  1, 8'h04, 0, 1, 1, 16'd1);
        tbl[14] = mk(1, 0, 8'h00, 0,  0, 8'h04, 0, 1, 1, 16'd1);

        bus.enable_i = 1'b0; bus.prop_valid_i = 1'b0; bus.prop_i = 8'h00; bus.stall_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_am_reset", 32'(bus.am_reset_o), 32'd1);
        chk("reset_run",      32'(bus.run_o),      32'd0);
        chk("reset_symbols",  32'(bus.symbols_o),  32'd0);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].en, tbl[i].pv, tbl[i].p, tbl[i].st);
            chk("tbl_run",  32'(bus.run_o),      32'(tbl[i].x_run));
            chk("tbl_sym",  32'(bus.symbols_o),  32'(tbl[i].x_sym));
            chk("tbl_amr",  32'(bus.am_reset_o), 32'(tbl[i].x_amr));
            chk("tbl_busy", 32'(bus.busy_o),     32'(tbl[i].x_busy));
            chk("tbl_ovf",  32'(bus.overflow_o), 32'(tbl[i].x_ovf));
            chk("tbl_drop", 32'(bus.drop_cnt_o), 32'(tbl[i].x_drop));
            if (i == 4) chk("first_sym_cnt", bus.sym_cnt_o, 32'd1);
        end

        // Full FIFO with a pop and a push on the same edge: no drop.
        got.delete();
        for (int i = 0; i < 4; i++) step(1, 1, 8'hC1 + 8'(i), 1);
        step(1, 1, 8'hAA, 0); collect();
        for (int i = 0; i < 5; i++) begin step(1, 0, 8'h00, 0); collect(); end
        want = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hAA};
        cmp_stream("fullpop_order");
        chk("fullpop_drop", 32'(bus.drop_cnt_o), 32'd1);

        // Drain three queued symbols after enable falls; later samples ignored.
        got.delete();
        step(1, 1, 8'h11, 1); step(1, 1, 8'h22, 1); step(1, 1, 8'h33, 1);
        step(0, 0, 8'h00, 0); collect();
        for (int i = 0; i < 10 && bus.busy_o; i++) begin step(0, 1, 8'h77, 0); collect(); end
        want = '{8'h11, 8'h22, 8'h33};
        cmp_stream("drain_order");
        chk("drain_busy", 32'(bus.busy_o),     32'd0);
        chk("drain_amr",  32'(bus.am_reset_o), 32'd1);

        // Abort during ARM, then re-arm with nothing queued.
        any_run = 1'b0;
        step(1, 0, 8'h00, 0); step(1, 1, 8'h5A, 0); any_run |= bus.run_o;
        step(0, 0, 8'h00, 0); any_run |= bus.run_o;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin step(1, 0, 8'h00, 0); any_run |= bus.run_o; end
        chk("abort_no_run", 32'(any_run), 32'd0);
        step(0, 0, 8'h00, 0);

        // Asynchronous reset in the middle of streaming.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 8'h42 + 8'(i), 0);
        chk("pre_reset_streaming", 32'(bus.am_reset_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_run", 32'(bus.run_o),      32'd0);
        chk("async_rst_amr", 32'(bus.am_reset_o), 32'd1);
        chk("async_rst_cnt", bus.sym_cnt_o,       32'd0);
        chk("async_rst_busy", 32'(bus.busy_o),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized sessions against the reference model.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) en_r = ~en_r;
            step(en_r, ($urandom_range(0, 99) < 65), 8'($urandom), ($urandom_range(0, 99) < 40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
